// File: rtl/vga_pkg.sv
// Shared VGA types, default 640x480@60 timing and helpers for mode-derived sizes.
package vga_pkg;

  typedef logic [11:0] rgb444_t;

  localparam int unsigned VGA640_H_VISIBLE = 640;
  localparam int unsigned VGA640_H_FRONT   = 16;
  localparam int unsigned VGA640_H_SYNC    = 96;
  localparam int unsigned VGA640_H_BACK    = 48;
  localparam int unsigned VGA640_V_VISIBLE = 480;
  localparam int unsigned VGA640_V_FRONT   = 10;
  localparam int unsigned VGA640_V_SYNC    = 2;
  localparam int unsigned VGA640_V_BACK    = 33;

  // Total period of one axis: visible + front porch + sync + back porch.
  function automatic int unsigned vga_total(input int unsigned visible,
                                            input int unsigned front,
                                            input int unsigned sync,
                                            input int unsigned back);
    return visible + front + sync + back;
  endfunction

  // Counter/address width for n states, never below one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_timing_fb_if.sv
// Framebuffer write port, colour inputs and timed VGA outputs of vga_timing_fb.
interface vga_timing_fb_if
  import vga_pkg::*;
#(
  parameter int unsigned CW = 5,
  parameter int unsigned RW = 4,
  parameter int unsigned HW = 10,
  parameter int unsigned VW = 10
);
  logic          wr_en;
  logic [CW-1:0] wr_col;
  logic [RW-1:0] wr_row;
  logic          wr_data;
  rgb444_t       fg;
  rgb444_t       bg;
  rgb444_t       rgb;
  logic          hs;
  logic          vs;
  logic          de;
  logic [HW-1:0] x;
  logic [VW-1:0] y;
  logic          line_start;
  logic          frame_start;

  modport master (
    output wr_en, wr_col, wr_row, wr_data, fg, bg,
    input  rgb, hs, vs, de, x, y, line_start, frame_start
  );

  modport slave (
    input  wr_en, wr_col, wr_row, wr_data, fg, bg,
    output rgb, hs, vs, de, x, y, line_start, frame_start
  );
endinterface

// File: rtl/vga_counter.sv
// Horizontal/vertical raster counters with unregistered sync, active-area and start decode.
module vga_counter
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = VGA640_H_VISIBLE,
  parameter int unsigned H_FRONT   = VGA640_H_FRONT,
  parameter int unsigned H_SYNC    = VGA640_H_SYNC,
  parameter int unsigned H_BACK    = VGA640_H_BACK,
  parameter int unsigned V_VISIBLE = VGA640_V_VISIBLE,
  parameter int unsigned V_FRONT   = VGA640_V_FRONT,
  parameter int unsigned V_SYNC    = VGA640_V_SYNC,
  parameter int unsigned V_BACK    = VGA640_V_BACK,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0,
  localparam int unsigned H_TOTAL  = vga_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK),
  localparam int unsigned V_TOTAL  = vga_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK),
  localparam int unsigned HW       = width_of(H_TOTAL),
  localparam int unsigned VW       = width_of(V_TOTAL)
)(
  input  logic          clk,
  input  logic          rst,
  output logic [HW-1:0] h_cnt_o,
  output logic [VW-1:0] v_cnt_o,
  output logic          active_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          line_start_o,
  output logic          frame_start_o
);

  // One spare bit so boundaries equal to the total never truncate.
  localparam logic [HW:0] H_LAST   = (HW+1)'(H_TOTAL - 1);
  localparam logic [HW:0] H_VIS    = (HW+1)'(H_VISIBLE);
  localparam logic [HW:0] HS_BEGIN = (HW+1)'(H_VISIBLE + H_FRONT);
  localparam logic [HW:0] HS_END   = (HW+1)'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW:0] V_LAST   = (VW+1)'(V_TOTAL - 1);
  localparam logic [VW:0] V_VIS    = (VW+1)'(V_VISIBLE);
  localparam logic [VW:0] VS_BEGIN = (VW+1)'(V_VISIBLE + V_FRONT);
  localparam logic [VW:0] VS_END   = (VW+1)'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [HW:0]   h_ext;
  logic [VW:0]   v_ext;

  assign h_ext = {1'b0, h_q};
  assign v_ext = {1'b0, v_q};

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_ext == H_LAST) begin
      h_d = '0;
      v_d = (v_ext == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Stage p0 boundary: decode straight from the counter state.
  assign h_cnt_o       = h_q;
  assign v_cnt_o       = v_q;
  assign active_o      = (h_ext < H_VIS) && (v_ext < V_VIS);
  assign hsync_o       = ((h_ext >= HS_BEGIN) && (h_ext < HS_END)) ? HS_POL : ~HS_POL;
  assign vsync_o       = ((v_ext >= VS_BEGIN) && (v_ext < VS_END)) ? VS_POL : ~VS_POL;
  assign line_start_o  = (h_q == '0);
  assign frame_start_o = (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/vga_timing_fb.sv
// VGA timing generator with a 1-bit-per-cell framebuffer selecting fg/bg per pixel.
module vga_timing_fb
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = VGA640_H_VISIBLE,
  parameter int unsigned H_FRONT    = VGA640_H_FRONT,
  parameter int unsigned H_SYNC     = VGA640_H_SYNC,
  parameter int unsigned H_BACK     = VGA640_H_BACK,
  parameter int unsigned V_VISIBLE  = VGA640_V_VISIBLE,
  parameter int unsigned V_FRONT    = VGA640_V_FRONT,
  parameter int unsigned V_SYNC     = VGA640_V_SYNC,
  parameter int unsigned V_BACK     = VGA640_V_BACK,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int unsigned CELL_SHIFT = 5,
  parameter int unsigned FB_COLS    = 20,
  parameter int unsigned FB_ROWS    = 15
)(
  input  logic            clk,
  input  logic            rst,
  vga_timing_fb_if.slave  bus
);

  localparam int unsigned H_TOTAL = vga_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = vga_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int unsigned HW      = width_of(H_TOTAL);
  localparam int unsigned VW      = width_of(V_TOTAL);
  localparam int unsigned CW      = width_of(FB_COLS);
  localparam int unsigned RW      = width_of(FB_ROWS);

  logic [HW-1:0] h_cnt_p0;
  logic [VW-1:0] v_cnt_p0;
  logic          vld_p0;
  logic          hs_p0;
  logic          vs_p0;
  logic          ls_p0;
  logic          fs_p0;

  vga_counter #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK),
    .HS_POL    (HS_POL),
    .VS_POL    (VS_POL)
  ) u_counter (
    .clk           (clk),
    .rst           (rst),
    .h_cnt_o       (h_cnt_p0),
    .v_cnt_o       (v_cnt_p0),
    .active_o      (vld_p0),
    .hsync_o       (hs_p0),
    .vsync_o       (vs_p0),
    .line_start_o  (ls_p0),
    .frame_start_o (fs_p0)
  );

  logic [FB_ROWS-1:0][FB_COLS-1:0] fb_q;

  logic [HW-1:0] cell_col_p0;
  logic [VW-1:0] cell_row_p0;
  logic [CW-1:0] rd_col_p0;
  logic [RW-1:0] rd_row_p0;
  logic          cell_in_p0;
  logic          cell_bit_p0;
  logic          wr_ok;

  assign cell_col_p0 = h_cnt_p0 >> CELL_SHIFT;
  assign cell_row_p0 = v_cnt_p0 >> CELL_SHIFT;
  assign cell_in_p0  = (32'(cell_col_p0) < FB_COLS) && (32'(cell_row_p0) < FB_ROWS);
  assign rd_col_p0   = CW'(cell_col_p0);
  assign rd_row_p0   = RW'(cell_row_p0);
  // Reads the registered array, so a same-cycle write to this cell is not yet visible.
  assign cell_bit_p0 = cell_in_p0 ? fb_q[rd_row_p0][rd_col_p0] : 1'b0;

  assign wr_ok = bus.wr_en && (32'(bus.wr_col) < FB_COLS) && (32'(bus.wr_row) < FB_ROWS);

  always_ff @(posedge clk) begin
    if (rst) begin
      fb_q <= '0;
    end else if (wr_ok) begin
      fb_q[bus.wr_row][bus.wr_col] <= bus.wr_data;
    end
  end

  // Stage p1 boundary: every output registered together from the p0 counter state.
  rgb444_t       rgb_p1_q, rgb_p1_d;
  logic [HW-1:0] x_p1_q;
  logic [VW-1:0] y_p1_q;
  logic          vld_p1_q;
  logic          hs_p1_q;
  logic          vs_p1_q;
  logic          ls_p1_q;
  logic          fs_p1_q;

  always_comb begin
    rgb_p1_d = '0;
    if (vld_p0) begin
      rgb_p1_d = cell_bit_p0 ? bus.fg : bus.bg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_p1_q <= '0;
      x_p1_q   <= '0;
      y_p1_q   <= '0;
      vld_p1_q <= 1'b0;
      hs_p1_q  <= ~HS_POL;
      vs_p1_q  <= ~VS_POL;
      ls_p1_q  <= 1'b0;
      fs_p1_q  <= 1'b0;
    end else begin
      rgb_p1_q <= rgb_p1_d;
      x_p1_q   <= h_cnt_p0;
      y_p1_q   <= v_cnt_p0;
      vld_p1_q <= vld_p0;
      hs_p1_q  <= hs_p0;
      vs_p1_q  <= vs_p0;
      ls_p1_q  <= ls_p0;
      fs_p1_q  <= fs_p0;
    end
  end

  assign bus.rgb         = rgb_p1_q;
  assign bus.x           = x_p1_q;
  assign bus.y           = y_p1_q;
  assign bus.de          = vld_p1_q;
  assign bus.hs          = hs_p1_q;
  assign bus.vs          = vs_p1_q;
  assign bus.line_start  = ls_p1_q;
  assign bus.frame_start = fs_p1_q;

endmodule

// File: tb/tb_vga_timing_fb.sv
// Directed bench: default 640x480 line timing, a 80x56 mode for frame/pixel checks, a 12x7 mode for reset.
module tb_vga_timing_fb;
  import vga_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;

  int checks = 0;
  int errors = 0;

  // A: default 640x480, 20x15 cells of 32 px
  vga_timing_fb_if #(.CW(5), .RW(4), .HW(10), .VW(10)) if_a ();
  vga_timing_fb dut_a (.clk(clk), .rst(rst_a), .bus(if_a));

  // B: 64x48 visible, H 64/4/8/4 = 80, V 48/2/2/4 = 56, 8 px cells, 6x6 cells
  vga_timing_fb_if #(.CW(3), .RW(3), .HW(7), .VW(6)) if_b ();
  vga_timing_fb #(
    .H_VISIBLE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_VISIBLE(48), .V_FRONT(2), .V_SYNC(2), .V_BACK(4),
    .HS_POL(1'b0), .VS_POL(1'b0),
    .CELL_SHIFT(3), .FB_COLS(6), .FB_ROWS(6)
  ) dut_b (.clk(clk), .rst(rst_b), .bus(if_b));

  // C: reduced H 8/1/2/1 = 12, V 4/1/1/1 = 7, positive syncs, 2 px cells, 4x2 cells
  vga_timing_fb_if #(.CW(2), .RW(1), .HW(4), .VW(3)) if_c ();
  vga_timing_fb #(
    .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HS_POL(1'b1), .VS_POL(1'b1),
    .CELL_SHIFT(1), .FB_COLS(4), .FB_ROWS(2)
  ) dut_c (.clk(clk), .rst(rst_c), .bus(if_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int n, p, ex, ey, hs_cnt, hs_first, de_cnt, de_blank, vs_cnt, vs_ymin, vs_ymax, rgb_bad, pos_bad;
  logic [11:0] exp_rgb;
  logic [11:0] spot_in1, spot_in2, spot_left, spot_below, spot_col6, spot_blank;

  initial begin
    if_a.wr_en = 1'b0; if_a.wr_col = '0; if_a.wr_row = '0; if_a.wr_data = 1'b0;
    if_a.fg = 12'hF00; if_a.bg = 12'h00F;
    if_b.wr_en = 1'b0; if_b.wr_col = '0; if_b.wr_row = '0; if_b.wr_data = 1'b0;
    if_b.fg = 12'hF00; if_b.bg = 12'h00F;
    if_c.wr_en = 1'b0; if_c.wr_col = '0; if_c.wr_row = '0; if_c.wr_data = 1'b0;
    if_c.fg = 12'hF00; if_c.bg = 12'h00F;

    // ---------------- A: reset values and default line timing
    repeat (5) tick();
    chk("a_rst_hs",  32'(if_a.hs), 32'd1);
    chk("a_rst_vs",  32'(if_a.vs), 32'd1);
    chk("a_rst_de",  32'(if_a.de), 32'd0);
    chk("a_rst_rgb", 32'(if_a.rgb), 32'h000);
    chk("a_rst_x",   32'(if_a.x), 32'd0);
    chk("a_rst_y",   32'(if_a.y), 32'd0);
    chk("a_rst_fs",  32'(if_a.frame_start), 32'd0);
    chk("a_rst_ls",  32'(if_a.line_start), 32'd0);

    rst_a = 1'b0;
    tick();
    chk("a_first_fs",  32'(if_a.frame_start), 32'd1);
    chk("a_first_ls",  32'(if_a.line_start), 32'd1);
    chk("a_first_x",   32'(if_a.x), 32'd0);
    chk("a_first_de",  32'(if_a.de), 32'd1);
    chk("a_first_rgb", 32'(if_a.rgb), 32'h00F);

    n = 0; hs_cnt = 0; hs_first = -1; de_cnt = 0;
    do begin
      if (!if_a.hs) begin
        if (hs_cnt == 0) hs_first = int'(if_a.x);
        hs_cnt++;
      end
      if (if_a.de) de_cnt++;
      tick();
      n++;
    end while (!if_a.line_start && n < 2000);
    chk("a_line_period", 32'(n), 32'd800);
    chk("a_hs_width",    32'(hs_cnt), 32'd96);
    chk("a_hs_start",    32'(hs_first), 32'd656);
    chk("a_de_per_line", 32'(de_cnt), 32'd640);
    chk("a_line1_y",     32'(if_a.y), 32'd1);
    chk("a_line1_x",     32'(if_a.x), 32'd0);
    rst_a = 1'b1;

    // ---------------- B: frame timing, pixel content, same-cycle hazard
    chk("b_rst_hs", 32'(if_b.hs), 32'd1);
    chk("b_rst_vs", 32'(if_b.vs), 32'd1);
    // Write cell (0,0) while the counters sit at (0,0).
    if_b.wr_en = 1'b1; if_b.wr_col = 3'd0; if_b.wr_row = 3'd0; if_b.wr_data = 1'b1;
    rst_b = 1'b0;
    tick();
    chk("b_first_fs", 32'(if_b.frame_start), 32'd1);
    chk("b_hazard_bg", 32'(if_b.rgb), 32'h00F);

    n = 0; p = 0; vs_cnt = 0; vs_ymin = 999; vs_ymax = -1; de_cnt = 0; de_blank = 0;
    rgb_bad = 0; pos_bad = 0;
    spot_in1 = 12'hABC; spot_in2 = 12'hABC; spot_left = 12'hABC;
    spot_below = 12'hABC; spot_col6 = 12'hABC; spot_blank = 12'hABC;
    do begin
      ex = p % 80;
      ey = (p / 80) % 56;
      if (int'(if_b.x) != ex || int'(if_b.y) != ey) pos_bad++;
      if (!if_b.vs) begin
        vs_cnt++;
        if (ey < vs_ymin) vs_ymin = ey;
        if (ey > vs_ymax) vs_ymax = ey;
      end
      if (if_b.de) begin
        de_cnt++;
        if (ey >= 48) de_blank++;
      end
      exp_rgb = 12'h000;
      if (ex < 64 && ey < 48) begin
        if ((p >= 1 && ex < 8 && ey < 8) || (ex / 8 == 3 && ey / 8 == 2)) exp_rgb = 12'hF00;
        else exp_rgb = 12'h00F;
      end
      if (if_b.rgb !== exp_rgb) rgb_bad++;
      if (ex == 24 && ey == 16) spot_in1 = if_b.rgb;
      if (ex == 31 && ey == 23) spot_in2 = if_b.rgb;
      if (ex == 23 && ey == 16) spot_left = if_b.rgb;
      if (ex == 24 && ey == 24) spot_below = if_b.rgb;
      if (ex == 48 && ey == 0)  spot_col6 = if_b.rgb;
      if (ex == 70 && ey == 10) spot_blank = if_b.rgb;
      if (p == 0) begin
        if_b.wr_col = 3'd3; if_b.wr_row = 3'd2; if_b.wr_data = 1'b1;
      end else if (p == 1) begin
        if_b.wr_col = 3'd6; if_b.wr_row = 3'd0; if_b.wr_data = 1'b1;
      end else begin
        if_b.wr_en = 1'b0;
      end
      tick();
      n++;
      p++;
    end while (!if_b.frame_start && n < 10000);
    chk("b_frame_period", 32'(n), 32'd4480);
    chk("b_pos_bad",      32'(pos_bad), 32'd0);
    chk("b_vs_samples",   32'(vs_cnt), 32'd160);
    chk("b_vs_first_ln",  32'(vs_ymin), 32'd50);
    chk("b_vs_last_ln",   32'(vs_ymax), 32'd51);
    chk("b_de_total",     32'(de_cnt), 32'd3072);
    chk("b_de_blank",     32'(de_blank), 32'd0);
    chk("b_rgb_bad",      32'(rgb_bad), 32'd0);
    chk("b_cell32_tl",    32'(spot_in1), 32'hF00);
    chk("b_cell32_br",    32'(spot_in2), 32'hF00);
    chk("b_cell22_edge",  32'(spot_left), 32'h00F);
    chk("b_cell33_edge",  32'(spot_below), 32'h00F);
    chk("b_col6_ignored", 32'(spot_col6), 32'h00F);
    chk("b_hblank_rgb",   32'(spot_blank), 32'h000);
    chk("b_next_frame_x", 32'(if_b.x), 32'd0);
    chk("b_next_frame_y", 32'(if_b.y), 32'd0);
    chk("b_next_frame_fg", 32'(if_b.rgb), 32'hF00);
    rst_b = 1'b1;

    // ---------------- C: reduced mode, positive syncs, mid-frame reset
    chk("c_rst_hs", 32'(if_c.hs), 32'd0);
    chk("c_rst_vs", 32'(if_c.vs), 32'd0);
    chk("c_rst_de", 32'(if_c.de), 32'd0);
    rst_c = 1'b0;
    tick();
    chk("c_first_fs", 32'(if_c.frame_start), 32'd1);
    chk("c_first_ls", 32'(if_c.line_start), 32'd1);
    chk("c_first_x",  32'(if_c.x), 32'd0);
    if_c.wr_en = 1'b1; if_c.wr_col = 2'd1; if_c.wr_row = 1'd0; if_c.wr_data = 1'b1;
    tick();
    if_c.wr_en = 1'b0;
    tick();
    chk("c_cell10_x",  32'(if_c.x), 32'd2);
    chk("c_cell10_fg", 32'(if_c.rgb), 32'hF00);

    n = 0;
    while (!if_c.line_start && n < 100) begin tick(); n++; end
    n = 0; hs_cnt = 0; hs_first = -1;
    do begin
      if (if_c.hs) begin
        if (hs_cnt == 0) hs_first = int'(if_c.x);
        hs_cnt++;
      end
      tick();
      n++;
    end while (!if_c.line_start && n < 100);
    chk("c_line_period", 32'(n), 32'd12);
    chk("c_hs_width",    32'(hs_cnt), 32'd2);
    chk("c_hs_start",    32'(hs_first), 32'd9);

    n = 0;
    while (!if_c.frame_start && n < 200) begin tick(); n++; end
    n = 0;
    do begin tick(); n++; end while (!if_c.frame_start && n < 200);
    chk("c_frame_period", 32'(n), 32'd84);

    repeat (30) tick();
    chk("c_mid_y", 32'(if_c.y), 32'd2);
    chk("c_mid_x", 32'(if_c.x), 32'd6);
    rst_c = 1'b1;
    tick();
    chk("c_rst2_x",   32'(if_c.x), 32'd0);
    chk("c_rst2_y",   32'(if_c.y), 32'd0);
    chk("c_rst2_de",  32'(if_c.de), 32'd0);
    chk("c_rst2_rgb", 32'(if_c.rgb), 32'h000);
    chk("c_rst2_hs",  32'(if_c.hs), 32'd0);
    rst_c = 1'b0;
    tick();
    chk("c_restart_fs", 32'(if_c.frame_start), 32'd1);
    chk("c_restart_x",  32'(if_c.x), 32'd0);
    chk("c_restart_y",  32'(if_c.y), 32'd0);
    tick();
    tick();
    chk("c_cleared_x",   32'(if_c.x), 32'd2);
    chk("c_cleared_rgb", 32'(if_c.rgb), 32'h00F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
